// File: rtl/memory_stage.sv
// Memory pipeline stage: M register, data-memory handshake FSM, store lane formatting, load extraction.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses via o_MisalignM.
module memory_stage (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [31:0] i_ALUResultE,
  input  logic [31:0] i_WriteDataE,
  input  logic [31:0] i_PCPlus4E,
  input  logic [4:0]  i_RdE,
  input  logic [2:0]  i_Funct3E,
  input  logic [1:0]  i_ResultSrcE,
  input  logic        i_RegWriteE,
  input  logic        i_MemWriteE,
  input  logic        i_MemReadE,
  output logic [31:0] o_ALUResultM,
  output logic [31:0] o_ReadDataM,
  output logic [31:0] o_PCPlus4M,
  output logic [4:0]  o_RdM,
  output logic [1:0]  o_ResultSrcM,
  output logic        o_RegWriteM,
  output logic        o_DMemReq,
  output logic        o_DMemWe,
  output logic [31:0] o_DMemAddr,
  output logic [31:0] o_DMemWData,
  output logic [3:0]  o_DMemBe,
  output logic        o_StallM,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        o_MisalignM,
`endif
  input  logic        i_DMemAck,
  input  logic [31:0] i_DMemRData
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_next;
  logic [31:0] alu_m, wdata_m, pc4_m;
  logic [4:0]  rd_m;
  logic [2:0]  funct3_m;
  logic [1:0]  result_src_m;
  logic        reg_write_m, mem_write_m, mem_read_m;
  logic        misalign, mem_req, stall;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data, store_data;
  logic [3:0]  store_be;

  // M register: frozen while the memory access is still outstanding
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      alu_m        <= 32'd0;
      wdata_m      <= 32'd0;
      pc4_m        <= 32'd0;
      rd_m         <= 5'd0;
      funct3_m     <= 3'd0;
      result_src_m <= 2'd0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_read_m   <= 1'b0;
    end else if (!stall) begin
      alu_m        <= i_ALUResultE;
      wdata_m      <= i_WriteDataE;
      pc4_m        <= i_PCPlus4E;
      rd_m         <= i_RdE;
      funct3_m     <= i_Funct3E;
      result_src_m <= i_ResultSrcE;
      reg_write_m  <= i_RegWriteE;
      mem_write_m  <= i_MemWriteE;
      mem_read_m   <= i_MemReadE;
    end else begin
      alu_m <= alu_m;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalignment detect: word needs addr[1:0]==0, halfword needs addr[0]==0
  always_comb begin
    misalign = 1'b0;
    if (mem_read_m || mem_write_m) begin
      if (funct3_m == 3'b010) begin
        misalign = (alu_m[1:0] != 2'b00);
      end else if ((funct3_m == 3'b001) || (mem_read_m && (funct3_m == 3'b101))) begin
        misalign = alu_m[0];
      end else begin
        misalign = 1'b0;
      end
    end else begin
      misalign = 1'b0;
    end
  end
  assign o_MisalignM = misalign;
`else
  assign misalign = 1'b0;
`endif

  assign mem_req = (mem_read_m || mem_write_m) && !misalign;
  assign stall   = mem_req && !i_DMemAck;

  // Handshake state register
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: wait out ack-less request cycles
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mem_req && !i_DMemAck) state_next = WAIT;
        else                       state_next = IDLE;
      end
      WAIT: begin
        if (i_DMemAck) state_next = IDLE;
        else           state_next = WAIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Store lane formatting: replicate narrow data so any byte enable sees it
  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata_m;
    case (funct3_m)
      3'b000: begin
        store_be   = 4'b0001 << alu_m[1:0];
        store_data = {4{wdata_m[7:0]}};
      end
      3'b001: begin
        store_be   = 4'b0011 << {alu_m[1], 1'b0};
        store_data = {2{wdata_m[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = wdata_m;
      end
    endcase
  end

  // Load extraction from the returned word
  always_comb begin
    byte_sel  = 8'd0;
    load_data = i_DMemRData;
    case (alu_m[1:0])
      2'b00:   byte_sel = i_DMemRData[7:0];
      2'b01:   byte_sel = i_DMemRData[15:8];
      2'b10:   byte_sel = i_DMemRData[23:16];
      default: byte_sel = i_DMemRData[31:24];
    endcase
    half_sel = alu_m[1] ? i_DMemRData[31:16] : i_DMemRData[15:0];
    case (funct3_m)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = i_DMemRData;
    endcase
  end

  assign o_DMemReq    = mem_req;
  assign o_DMemWe     = mem_write_m;
  assign o_DMemAddr   = {alu_m[31:2], 2'b00};
  assign o_DMemBe     = !mem_req ? 4'b0000 : (mem_write_m ? store_be : 4'b1111);
  assign o_DMemWData  = (mem_req && mem_write_m) ? store_data : 32'd0;
  assign o_StallM     = stall;
  assign o_ReadDataM  = (mem_req && mem_read_m && i_DMemAck) ? load_data : 32'd0;
  assign o_RegWriteM  = reg_write_m && !stall && !misalign;
  assign o_ALUResultM = alu_m;
  assign o_PCPlus4M   = pc4_m;
  assign o_RdM        = rd_m;
  assign o_ResultSrcM = result_src_m;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 i_Clk  in  1  sole clock; all state on rising edge.
REQ-002 i_Reset  in  1  asynchronous, active-high reset.
REQ-003 i_ALUResultE, i_WriteDataE, i_PCPlus4E  in  32 each  execute-stage address/result, store data, PC+4.
REQ-004 i_RdE  in  5; i_Funct3E  in  3; i_ResultSrcE  in  2; i_RegWriteE, i_MemWriteE, i_MemReadE  in  1 each  execute-stage destination, access width, control.
REQ-005 o_ALUResultM, o_ReadDataM, o_PCPlus4M  out  32 each; o_RdM  out  5; o_ResultSrcM  out  2; o_RegWriteM  out  1  toward writeback.
REQ-006 o_DMemReq, o_DMemWe  out  1; o_DMemAddr, o_DMemWData  out  32; o_DMemBe  out  4; i_DMemAck  in  1; i_DMemRData  in  32  data-memory port.
REQ-007 o_StallM  out  1  to hazard unit: freeze fetch/decode/execute.
REQ-008 o_MisalignM  out  1  misaligned-access flag (present only with MEM_MISALIGN_TRAP_EN).

Function
REQ-009 M register (ALUResult, WriteData, Rd, PCPlus4, Funct3, ResultSrc, RegWrite, MemWrite, MemRead) SHALL load execute inputs each edge where o_StallM=0 and hold when o_StallM=1.
REQ-010 FSM states IDLE, WAIT; IDLE->WAIT when memory op pending and i_DMemAck=0; WAIT->IDLE on i_DMemAck=1; IDLE stays IDLE otherwise.
REQ-011 Pending op = M holds MemRead or MemWrite and access not yet acknowledged; o_DMemReq=1 exactly while pending, held stable (addr, we, be, wdata) until ack.
REQ-012 Zero-wait: ack in the first request cycle completes the op with no stall; each additional ack-less cycle adds one stall cycle.
REQ-013 o_StallM = o_DMemReq AND NOT i_DMemAck (combinational).
REQ-014 o_RegWriteM SHALL be 0 whenever o_StallM=1 (bubble into writeback); else equals registered RegWrite.
REQ-015 o_DMemAddr = {ALUResultM[31:2],2'b00}; o_DMemWe = MemWriteM.
REQ-016 Stores: SB (000) be=0001<<addr[1:0], data byte replicated x4; SH (001) be=0011<<{addr[1],0}, halfword replicated x2; SW (010) be=1111.
REQ-017 Loads: be=1111; o_ReadDataM from i_DMemRData lane selected by addr[1:0]: LB sign-extended, LH sign-extended, LW raw, LBU/LHU zero-extended; valid in ack cycle; other funct3 -> LW behaviour.
REQ-018 o_ReadDataM = 0 when no load is being acknowledged.
REQ-019 Ack while o_DMemReq=0 SHALL be ignored; ack in WAIT completes exactly one op.
REQ-020 Back-to-back memory ops: next op requested the cycle after previous ack; no idle gap required.

Reset
REQ-021 Asserting i_Reset at any time (including mid-WAIT) SHALL force FSM=IDLE and all M register fields to 0; outstanding access abandoned, later ack ignored per REQ-019.
REQ-022 During reset: o_DMemReq=0, o_StallM=0, o_RegWriteM=0, o_MisalignM=0, all data outputs 0.

Configuration
REQ-023 Macro MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 SHALL set o_MisalignM=1 for that M cycle, suppress o_DMemReq, force o_RegWriteM=0, no stall.
REQ-024 Macro undefined: o_MisalignM port absent; misaligned addresses use REQ-016/017 lane rules with offending low bits ignored (LH/SH use addr[1]; LW/SW ignore addr[1:0]).

Verification
REQ-025 SW addr 0x100 data 0xDEADBEEF, ack same cycle -> one req, be=1111, wdata=0xDEADBEEF, o_StallM never 1.
REQ-026 LB addr 0x203, RData 0x80FFFFFF, ack after 3 cycles -> o_StallM=1 for 3 cycles, o_RegWriteM=0 during stall, o_ReadDataM=0xFFFFFF80 in ack cycle.
REQ-027 SH addr 0x302 data 0x00001234 -> be=1100, wdata=0x12341234; LHU same addr RData 0xABCD0000 -> 0x0000ABCD.
REQ-028 Reset asserted in WAIT cycle 2 of a load, late ack after deassert -> IDLE, no req, no stall, outputs 0.
REQ-029 LW addr 0x101: with MEM_MISALIGN_TRAP_EN -> o_MisalignM=1, no req; without -> req addr 0x100, full word returned.
REQ-030 LW then SW back-to-back, each acked in 1 cycle -> req continuous two cycles, stall only on ack-less cycles, correct be per op.
